alu_req_arbiter: RTL and testbench

Shares one ALU instance among NUM_REQ independent requesters. Accepts one operation at a time under round-robin arbitration, drives the ALU input bus for exactly one cycle, waits the fixed ALU latency, then returns the captured result to the granted requester tagged with its index. Sits between the requester-side logic and the ALU. Its ALU-side ports connect one-to-one to the ALU's operand, control and flag pins.

---
 rtl/alu_arb_pkg.sv | 37 +++
 rtl/alu_define.svh | 8 +
 rtl/alu_rr_picker.sv | 35 +++
 rtl/alu_req_arbiter.sv | 165 ++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU request arbiter: FSM states and the
// captured request/response records.
`include "alu_define.svh"

package alu_arb_pkg;

  // Widest requester index supported (NUM_REQ up to 8).
  localparam int ID_MAX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [`WIDTH-1:0]     opa;
    logic [`WIDTH-1:0]     opb;
    logic [`CMD_WIDTH-1:0] cmd;
    logic                  mode;
    logic                  cin;
    logic [1:0]            inp_valid;
    logic [ID_MAX_W-1:0]   id;
  } req_t;

  typedef struct packed {
    logic [`WIDTH:0] res;
    logic            oflow;
    logic            cout;
    logic            g;
    logic            l;
    logic            e;
    logic            err;
  } rsp_t;

endpackage

// File: rtl/alu_define.svh
`ifndef ALU_DEFINE_SVH
`define ALU_DEFINE_SVH

// Default ALU datapath sizing shared by the arbiter and its package.
`define WIDTH     8
`define CMD_WIDTH 4

`endif

// File: rtl/alu_rr_picker.sv
// Round-robin find-first: first set bit of valid at or above ptr,
// wrapping modulo NUM_REQ.
module alu_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  localparam int PW = IDW + 1;

  logic [PW-1:0] pos;

  // Scan NUM_REQ positions starting at ptr; the first valid one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr} + PW'(i);
      if (pos >= PW'(NUM_REQ)) pos = pos - PW'(NUM_REQ);
      if (!any && valid[pos[IDW-1:0]]) begin
        any                  = 1'b1;
        grant[pos[IDW-1:0]]  = 1'b1;
        idx                  = pos[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU among NUM_REQ requesters: round-robin grant, one-cycle
// issue, fixed-latency wait, then a held response tagged with the owner id.
`include "alu_define.svh"

module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = `WIDTH,
  parameter int CMD_WIDTH = `CMD_WIDTH,
  parameter int ALU_LAT   = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]       req_opa,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]       req_opb,
  input  logic [NUM_REQ-1:0][CMD_WIDTH-1:0]   req_cmd,
  input  logic [NUM_REQ-1:0]                  req_mode,
  input  logic [NUM_REQ-1:0]                  req_cin,
  input  logic [NUM_REQ-1:0][1:0]             req_inp_valid,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]          rsp_id,
  output logic [WIDTH:0]                      rsp_res,
  output logic                                rsp_oflow,
  output logic                                rsp_cout,
  output logic                                rsp_g,
  output logic                                rsp_l,
  output logic                                rsp_e,
  output logic                                rsp_err,
  output logic [WIDTH-1:0]                    alu_opa,
  output logic [WIDTH-1:0]                    alu_opb,
  output logic [CMD_WIDTH-1:0]                alu_cmd,
  output logic                                alu_mode,
  output logic                                alu_cin,
  output logic [1:0]                          alu_inp_valid,
  output logic                                alu_ce,
  input  logic [WIDTH:0]                      alu_res,
  input  logic                                alu_oflow,
  input  logic                                alu_cout,
  input  logic                                alu_g,
  input  logic                                alu_l,
  input  logic                                alu_e,
  input  logic                                alu_err
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  req_t               req_q, req_d;
  rsp_t               rsp_q, rsp_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  logic               issue;

  alu_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Next-state, request capture, pointer advance and response capture.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_d.opa       = req_opa[pick_idx];
          req_d.opb       = req_opb[pick_idx];
          req_d.cmd       = req_cmd[pick_idx];
          req_d.mode      = req_mode[pick_idx];
          req_d.cin       = req_cin[pick_idx];
          req_d.inp_valid = req_inp_valid[pick_idx];
          req_d.id        = ID_MAX_W'(pick_idx);
          ptr_d = (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + IDW'(1);
          if (req_inp_valid[pick_idx] != 2'b00) begin
            state_d = ISSUE;
          end else begin
            // No valid operands: answer with an error and never touch the ALU.
            rsp_d     = '0;
            rsp_d.err = 1'b1;
            state_d   = RESP;
          end
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(ALU_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_d.res   = alu_res;
          rsp_d.oflow = alu_oflow;
          rsp_d.cout  = alu_cout;
          rsp_d.g     = alu_g;
          rsp_d.l     = alu_l;
          rsp_d.e     = alu_e;
          rsp_d.err   = alu_err;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, counter and captured records; reset discards any operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      req_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
    end
  end

  // Grant only while idle; forced low while reset is asserted.
  assign req_ready = (state_q == IDLE && rst) ? pick_grant : '0;

  assign issue         = (state_q == ISSUE);
  assign alu_ce        = issue;
  assign alu_opa       = issue ? req_q.opa       : '0;
  assign alu_opb       = issue ? req_q.opb       : '0;
  assign alu_cmd       = issue ? req_q.cmd       : '0;
  assign alu_mode      = issue ? req_q.mode      : 1'b0;
  assign alu_cin       = issue ? req_q.cin       : 1'b0;
  assign alu_inp_valid = issue ? req_q.inp_valid : 2'b00;

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = IDW'(req_q.id);
  assign rsp_res   = rsp_q.res;
  assign rsp_oflow = rsp_q.oflow;
  assign rsp_cout  = rsp_q.cout;
  assign rsp_g     = rsp_q.g;
  assign rsp_l     = rsp_q.l;
  assign rsp_e     = rsp_q.e;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-timeline reference model.
module tb_alu_req_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int CW  = 4;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [N-1:0]          req_valid = '0;
  logic [N-1:0]          req_ready;
  logic [N-1:0][W-1:0]   req_opa = '0;
  logic [N-1:0][W-1:0]   req_opb = '0;
  logic [N-1:0][CW-1:0]  req_cmd = '0;
  logic [N-1:0]          req_mode = '0;
  logic [N-1:0]          req_cin = '0;
  logic [N-1:0][1:0]     req_inp_valid = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [1:0]            rsp_id;
  logic [W:0]            rsp_res;
  logic                  rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e, rsp_err;
  logic [W-1:0]          alu_opa, alu_opb;
  logic [CW-1:0]         alu_cmd;
  logic                  alu_mode, alu_cin, alu_ce;
  logic [1:0]            alu_inp_valid;
  logic [W:0]            alu_res;
  logic                  alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_err;

  always #5 clk = ~clk;

  alu_req_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .CMD_WIDTH(CW), .ALU_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
    .req_mode(req_mode), .req_cin(req_cin), .req_inp_valid(req_inp_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_oflow(rsp_oflow), .rsp_cout(rsp_cout),
    .rsp_g(rsp_g), .rsp_l(rsp_l), .rsp_e(rsp_e), .rsp_err(rsp_err),
    .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cmd(alu_cmd),
    .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_inp_valid(alu_inp_valid),
    .alu_ce(alu_ce),
    .alu_res(alu_res), .alu_oflow(alu_oflow), .alu_cout(alu_cout),
    .alu_g(alu_g), .alu_l(alu_l), .alu_e(alu_e), .alu_err(alu_err)
  );

  // Behavioural ALU: {res, oflow, cout, g, l, e, err}
  function automatic logic [14:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] c, input logic m,
                                         input logic ci, input logic [1:0] iv);
    logic [8:0] r;
    case (c[1:0])
      2'd0:    r = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      2'd1:    r = {1'b0, a} - {1'b0, b} - {8'd0, ci};
      2'd2:    r = {1'b0, a & b};
      default: r = {m, a ^ b};
    endcase
    return {r, m ^ r[8], r[8], a > b, a < b, a == b, iv != 2'b11};
  endfunction

  // ALU stub with one cycle of latency; outputs are junk except in the
  // cycle after an issue, so a mistimed capture shows up.
  always @(posedge clk) begin
    if (alu_ce)
      {alu_res, alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_err} <=
        alu_fn(alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_inp_valid);
    else
      {alu_res, alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_err} <= 15'($urandom);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction with its issue/response cycles.
  int          cyc = 0;
  int          m_ptr = 0;
  bit          m_busy = 0;
  int          m_id = 0;
  int          m_issue_cyc = -1;
  int          m_rsp_cyc = 0;
  logic [23:0] m_bus = '0;
  logic [14:0] m_rsp = '0;
  int          last_win = -1;

  // Called at a negedge with inputs already driven: check outputs, advance model, move one cycle.
  task automatic step();
    logic [N-1:0] exp_ready;
    bit exp_ce, exp_rv;
    int win;
    #1;
    exp_ready = '0;
    win = -1;
    if (rst && !m_busy) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (win < 0 && req_valid[j]) win = j;
      end
    end
    if (win >= 0) exp_ready[win] = 1'b1;
    check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
    exp_ce = rst && m_busy && (cyc == m_issue_cyc);
    check_eq("alu_bus",
      64'({alu_ce, alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_inp_valid}),
      exp_ce ? 64'({1'b1, m_bus}) : 64'd0);
    exp_rv = rst && m_busy && (cyc >= m_rsp_cyc);
    check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv) begin
      check_eq("rsp_data", 64'({rsp_res, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e, rsp_err}),
               64'(m_rsp));
      check_eq("rsp_id", 64'(rsp_id), 64'(m_id));
    end else if (!rst) begin
      check_eq("rsp_in_reset",
               64'({rsp_id, rsp_res, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e, rsp_err}), 64'd0);
    end
    last_win = -1;
    if (!rst) begin
      m_busy = 0;
      m_ptr  = 0;
    end else if (exp_rv && rsp_ready) begin
      m_busy = 0;
    end else if (win >= 0) begin
      last_win = win;
      m_busy   = 1;
      m_id     = win;
      m_ptr    = (win + 1) % N;
      m_bus    = {req_opa[win], req_opb[win], req_cmd[win], req_mode[win],
                  req_cin[win], req_inp_valid[win]};
      if (req_inp_valid[win] == 2'b00) begin
        m_rsp       = 15'd1;
        m_issue_cyc = -1;
        m_rsp_cyc   = cyc + 1;
      end else begin
        m_rsp       = alu_fn(req_opa[win], req_opb[win], req_cmd[win], req_mode[win],
                             req_cin[win], req_inp_valid[win]);
        m_issue_cyc = cyc + 1;
        m_rsp_cyc   = cyc + 2 + LAT;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] c, input logic m, input logic ci,
                         input logic [1:0] iv);
    req_valid[i]     = 1'b1;
    req_opa[i]       = a;
    req_opb[i]       = b;
    req_cmd[i]       = c;
    req_mode[i]      = m;
    req_cin[i]       = ci;
    req_inp_valid[i] = iv;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3)));
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 20 && m_busy; t++) step();
    check_eq("idle_reached", 64'(m_busy), 64'd0);
  endtask

  task automatic run_until_grant(output int w);
    w = -1;
    for (int t = 0; t < 20 && w < 0; t++) begin
      step();
      w = last_win;
    end
  endtask

  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      if (i == last_win || !req_valid[i]) begin
        if ($urandom_range(0, 9) < 6) rand_req(i);
        else req_valid[i] = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        req_valid[i] = 1'b0;
      end
    end
    rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int gq[$];
    int w;
    int stalled_id;
    @(negedge clk);

    // Reset state: everything low, even with requests pending.
    req_valid = 4'b1111;
    step();
    step();
    req_valid = '0;
    rst = 1'b1;
    step();

    // Single ADD from requester 0.
    set_req(0, 8'h05, 8'h03, 4'h0, 1'b0, 1'b0, 2'b11);
    rsp_ready = 1'b1;
    step();
    check_eq("single_grant", 64'(last_win), 64'd0);
    req_valid = '0;
    step();
    step();
    #1;
    check_eq("single_rsp_valid", 64'(rsp_valid), 64'd1);
    check_eq("single_rsp_id", 64'(rsp_id), 64'd0);
    check_eq("single_rsp_res", 64'(rsp_res), 64'h008);
    step();
    wait_idle();

    // All four valid from reset: grants rotate 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < N; i++) rand_req(i);
    for (int t = 0; t < 40; t++) begin
      step();
      if (last_win >= 0) begin
        gq.push_back(last_win);
        rand_req(last_win);
      end
    end
    check_eq("rr_count", 64'(gq.size() >= 8), 64'd1);
    for (int i = 0; i < 8 && i < gq.size(); i++)
      check_eq("rr_order", 64'(gq[i]), 64'(i % N));
    req_valid = '0;
    wait_idle();

    // Wrap-around: move ptr to 3, then req1 and req3 compete.
    do_reset();
    set_req(2, 8'h10, 8'h20, 4'h1, 1'b0, 1'b1, 2'b01);
    step();
    check_eq("wrap_setup", 64'(last_win), 64'd2);
    req_valid = '0;
    wait_idle();
    set_req(1, 8'hAA, 8'h55, 4'h2, 1'b1, 1'b0, 2'b11);
    set_req(3, 8'hFF, 8'h01, 4'h0, 1'b0, 1'b1, 2'b10);
    step();
    check_eq("wrap_first", 64'(last_win), 64'd3);
    req_valid[3] = 1'b0;
    run_until_grant(w);
    check_eq("wrap_next", 64'(w), 64'd1);
    req_valid = '0;
    wait_idle();

    // Error bypass: no operands valid on requester 2.
    set_req(2, 8'h12, 8'h34, 4'h0, 1'b0, 1'b0, 2'b00);
    run_until_grant(w);
    check_eq("err_grant", 64'(w), 64'd2);
    req_valid = '0;
    #1;
    check_eq("err_rsp_valid", 64'(rsp_valid), 64'd1);
    check_eq("err_flag", 64'(rsp_err), 64'd1);
    check_eq("err_res", 64'(rsp_res), 64'd0);
    check_eq("err_id", 64'(rsp_id), 64'd2);
    check_eq("err_no_ce", 64'(alu_ce), 64'd0);
    step();
    wait_idle();

    // Response stall with other requests pending.
    for (int i = 0; i < N; i++) rand_req(i);
    rsp_ready = 1'b0;
    run_until_grant(w);
    stalled_id = w;
    req_valid[w] = 1'b0;
    for (int t = 0; t < 5 + 2 + LAT; t++) step();
    rsp_ready = 1'b1;
    rand_req(stalled_id);
    step();
    run_until_grant(w);
    check_eq("stall_next", 64'(w), 64'((stalled_id + 1) % N));
    req_valid = '0;
    wait_idle();

    // Random traffic.
    for (int t = 0; t < 800; t++) begin
      drive_random();
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();

    // Reset while waiting on the ALU: response dropped, ptr back to 0.
    set_req(2, 8'h77, 8'h11, 4'h1, 1'b0, 1'b0, 2'b11);
    run_until_grant(w);
    req_valid = '0;
    step();
    rst = 1'b0;
    step();
    step();
    set_req(0, 8'h01, 8'h02, 4'h0, 1'b0, 1'b0, 2'b11);
    set_req(2, 8'h03, 8'h04, 4'h0, 1'b0, 1'b0, 2'b11);
    rst = 1'b1;
    step();
    check_eq("post_reset_grant", 64'(last_win), 64'd0);
    req_valid[0] = 1'b0;
    for (int t = 0; t < 12; t++) step();
    req_valid = '0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
